// File: rtl/rtc_pkg.sv
// rtc_pkg: time-of-day range limits, BCD widths and binary-to-BCD helper shared with the setting controller.
package rtc_pkg;
  localparam logic [31:0] SEC_MAX = 32'd59;
  localparam logic [31:0] MIN_MAX = 32'd59;
  localparam logic [31:0] HOUR_MAX = 32'd23;
  localparam int BCD_W = 4;
  localparam int BCD_FIELD_W = 2 * BCD_W;
  function automatic logic [BCD_FIELD_W-1:0] to_bcd(input logic [5:0] v);
    return {BCD_W'(v / 6'd10), BCD_W'(v % 6'd10)};
  endfunction
endpackage

// File: rtl/rtc_timekeeper_if.sv
// rtc_timekeeper_if: load/run controls in, binary/BCD time and event pulses out.
interface rtc_timekeeper_if;
  logic run_en;
  logic load;
  logic [31:0] sec_in;
  logic [31:0] min_in;
  logic [31:0] hour_in;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [23:0] bcd;
  logic sec_tick;
  logic day_wrap;
  logic load_ack;
  logic load_err;
  modport master (
    output run_en, load, sec_in, min_in, hour_in,
    input sec, min, hour, bcd, sec_tick, day_wrap, load_ack, load_err
  );
  modport slave (
    input run_en, load, sec_in, min_in, hour_in,
    output sec, min, hour, bcd, sec_tick, day_wrap, load_ack, load_err
  );
endinterface

// File: rtl/rtc_prescaler.sv
// rtc_prescaler: divides clk by CLK_HZ while run_en is high; tick marks the last cycle of each second.
module rtc_prescaler #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run_en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLK_HZ);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = run_en && (cnt_q == W'(CLK_HZ - 1));
  always_comb cnt_d = (clr || tick) ? '0 : run_en ? cnt_q + W'(1) : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: hh:mm:ss counter advanced once per second, loadable with range-checked values.
module rtc_timekeeper
  import rtc_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000
) (
  input logic clk,
  input logic rst,
  rtc_timekeeper_if.slave bus
);
  logic tick, valid, accept, sec_wrap, min_wrap, hour_wrap;
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hour_q, hour_d;
  logic [23:0] bcd_q, bcd_d;
  logic tick_q, tick_d, day_q, day_d, ack_q, ack_d, err_q, err_d;
  rtc_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
    .clk(clk),
    .rst(rst),
    .run_en(bus.run_en),
    .clr(accept),
    .tick(tick)
  );
  always_comb begin
    valid = (bus.sec_in <= SEC_MAX) && (bus.min_in <= MIN_MAX) && (bus.hour_in <= HOUR_MAX);
    accept = bus.load && valid;
    sec_wrap = sec_q == 6'(SEC_MAX);
    min_wrap = min_q == 6'(MIN_MAX);
    hour_wrap = hour_q == 5'(HOUR_MAX);
    tick_d = tick && !accept;
    sec_d = accept ? bus.sec_in[5:0] : tick ? (sec_wrap ? 6'd0 : sec_q + 6'd1) : sec_q;
    min_d = accept ? bus.min_in[5:0] : (tick && sec_wrap) ? (min_wrap ? 6'd0 : min_q + 6'd1) : min_q;
    hour_d = accept ? bus.hour_in[4:0]
           : (tick && sec_wrap && min_wrap) ? (hour_wrap ? 5'd0 : hour_q + 5'd1) : hour_q;
    day_d = tick_d && sec_wrap && min_wrap && hour_wrap;
    ack_d = accept;
    err_d = bus.load && !valid;
    bcd_d = {to_bcd({1'b0, hour_d}), to_bcd(min_d), to_bcd(sec_d)};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sec_q <= '0;
      min_q <= '0;
      hour_q <= '0;
      bcd_q <= '0;
      tick_q <= 1'b0;
      day_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      sec_q <= sec_d;
      min_q <= min_d;
      hour_q <= hour_d;
      bcd_q <= bcd_d;
      tick_q <= tick_d;
      day_q <= day_d;
      ack_q <= ack_d;
      err_q <= err_d;
    end
  assign bus.sec = sec_q;
  assign bus.min = min_q;
  assign bus.hour = hour_q;
  assign bus.bcd = bcd_q;
  assign bus.sec_tick = tick_q;
  assign bus.day_wrap = day_q;
  assign bus.load_ack = ack_q;
  assign bus.load_err = err_q;
endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: directed vectors with hand-computed expectations, CLK_HZ shrunk to 10.
module tb_rtc_timekeeper;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_pass = 0;
  rtc_timekeeper_if bus();
  rtc_timekeeper #(.CLK_HZ(10)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic do_load(input logic [31:0] s, input logic [31:0] m, input logic [31:0] h);
    bus.sec_in = s;
    bus.min_in = m;
    bus.hour_in = h;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
  endtask
  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, "_hour"}, 32'(bus.hour), 32'(h));
    check({tag, "_min"}, 32'(bus.min), 32'(m));
    check({tag, "_sec"}, 32'(bus.sec), 32'(s));
  endtask
  task automatic check_zero(input string tag);
    check_time(tag, 0, 0, 0);
    check({tag, "_bcd"}, 32'(bus.bcd), 32'h0);
    check({tag, "_pulses"}, {28'd0, bus.sec_tick, bus.day_wrap, bus.load_ack, bus.load_err}, 32'h0);
  endtask
  initial begin
    bus.run_en = 1'b0;
    bus.load = 1'b0;
    bus.sec_in = '0;
    bus.min_in = '0;
    bus.hour_in = '0;
    step(2);
    check_zero("reset");
    rst = 1'b0;
    bus.run_en = 1'b1;
    step(9);
    check("first_sec_early", 32'(bus.sec_tick), 32'd0);
    step(1);
    check("first_sec_tick", 32'(bus.sec_tick), 32'd1);
    check("first_sec_val", 32'(bus.sec), 32'd1);
    step(1);
    check("first_sec_tick_low", 32'(bus.sec_tick), 32'd0);
    step(3);
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    step(1);
    check_zero("rst_held");
    rst = 1'b0;
    step(9);
    check("rst_release_early", 32'(bus.sec_tick), 32'd0);
    step(1);
    check("rst_release_tick", 32'(bus.sec_tick), 32'd1);
    do_load(58, 0, 0);
    check("basic_ack", 32'(bus.load_ack), 32'd1);
    check("basic_bcd0", 32'(bus.bcd), 32'h000058);
    step(10);
    check_time("basic_59", 0, 0, 59);
    check("basic_tick1", 32'(bus.sec_tick), 32'd1);
    step(10);
    check_time("basic_100", 0, 1, 0);
    check("basic_tick2", 32'(bus.sec_tick), 32'd1);
    check("basic_bcd", 32'(bus.bcd), 32'h000100);
    do_load(59, 59, 23);
    check("mid_bcd0", 32'(bus.bcd), 32'h235959);
    step(10);
    check_time("midnight", 0, 0, 0);
    check("mid_tick", 32'(bus.sec_tick), 32'd1);
    check("mid_wrap", 32'(bus.day_wrap), 32'd1);
    check("mid_bcd", 32'(bus.bcd), 32'h000000);
    step(1);
    check("mid_wrap_low", 32'(bus.day_wrap), 32'd0);
    do_load(60, 5, 5);
    check("bad_sec_err", 32'(bus.load_err), 32'd1);
    check("bad_sec_ack", 32'(bus.load_ack), 32'd0);
    check_time("bad_sec", 0, 0, 0);
    do_load(0, 0, 32'h1000_0003);
    check("bad_hour_err", 32'(bus.load_err), 32'd1);
    check_time("bad_hour", 0, 0, 0);
    step(6);
    check("bad_keep_early", 32'(bus.sec_tick), 32'd0);
    step(1);
    check("bad_keep_tick", 32'(bus.sec_tick), 32'd1);
    check("bad_keep_sec", 32'(bus.sec), 32'd1);
    step(9);
    do_load(56, 34, 12);
    check_time("coll", 12, 34, 56);
    check("coll_no_tick", 32'(bus.sec_tick), 32'd0);
    check("coll_ack", 32'(bus.load_ack), 32'd1);
    check("coll_bcd", 32'(bus.bcd), 32'h123456);
    step(9);
    check("coll_early", 32'(bus.sec_tick), 32'd0);
    step(1);
    check("coll_tick", 32'(bus.sec_tick), 32'd1);
    check("coll_sec", 32'(bus.sec), 32'd57);
    step(4);
    bus.run_en = 1'b0;
    step(50);
    check("hold_sec", 32'(bus.sec), 32'd57);
    check("hold_tick", 32'(bus.sec_tick), 32'd0);
    bus.run_en = 1'b1;
    step(5);
    check("resume_early", 32'(bus.sec_tick), 32'd0);
    step(1);
    check("resume_tick", 32'(bus.sec_tick), 32'd1);
    check("resume_sec", 32'(bus.sec), 32'd58);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
